wb_master: RTL and testbench
============================

Name: wb_master

Overview:
- Wishbone B4 pipelined-mode single-transaction master, i.e. the initiator end of the bus served by wb_slave.
- Converts a simple valid/ready command interface into one bus cycle and returns a one-cycle response pulse carrying read data and error/timeout status.
- Sits between a test or control engine and wb_slave; drives the same adr/dat/sel/we/stb/cyc signal set that wb_slave receives.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 32, bus data width.
- GRANULE, 8, bits per select lane.
- SEL_WIDTH, DATA_WIDTH/GRANULE (localparam), select width.
- TIMEOUT, 255, cycles allowed from stb_o assertion to ack/err. 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  SEL_WIDTH  byte lanes.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_dat_o  out  DATA_WIDTH  read data. 0 for writes and errors.
- rsp_err_o  out  1  bus error or timeout.
- rsp_timeout_o  out  1  completion caused by timeout.
- adr_o  out  ADDR_WIDTH  bus address.
- dat_o  out  DATA_WIDTH  bus write data.
- dat_i  in  DATA_WIDTH  bus read data.
- sel_o  out  SEL_WIDTH  bus select.
- we_o  out  1  bus write enable.
- stb_o  out  1  bus strobe.
- cyc_o  out  1  bus cycle.
- ack_i  in  1  slave acknowledge.
- err_i  in  1  slave error.
- stall_i  in  1  slave stall.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_* and the timeout counter all clear to 0.
  - cmd_ready_o=1, since it is decoded from IDLE.
  - Reset mid-transaction drops cyc_o/stb_o immediately and produces no response.
- All outputs except cmd_ready_o are registered. cmd_ready_o = (state==IDLE).
- IDLE:
  - On cmd_valid_i & cmd_ready_o, latch the command and drive it on the bus.
  - Next cycle: cyc_o=stb_o=1, state REQ.
  - dat_o = cmd_dat_i for writes, 0 for reads. sel_o passes through unmodified, including 0.
- REQ:
  - stb_o, cyc_o, adr_o, dat_o, sel_o and we_o are held stable while stall_i=1.
  - At an edge with stall_i=0, the request is accepted: stb_o=0 next cycle, state WAIT.
  - If ack_i or err_i is also high at that edge, complete directly (see completion).
- WAIT:
  - cyc_o=1, stb_o=0.
  - Complete at the first edge with ack_i or err_i high.
- Completion:
  - Next cycle: rsp_valid_o=1 for exactly one cycle, cyc_o=0, state IDLE, so cmd_ready_o=1 in that same cycle.
  - ack_i only: rsp_err_o=0; rsp_dat_o = sampled dat_i for reads, 0 for writes.
  - err_i (with or without ack_i): rsp_err_o=1, rsp_dat_o=0. err takes priority.
- Timeout:
  - The counter starts at 0 on the first REQ cycle and increments every REQ/WAIT cycle.
  - If it reaches TIMEOUT without ack/err, abort. Next cycle: cyc_o=stb_o=0, rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, state IDLE.
  - An ack/err arriving in the same cycle as the timeout wins: normal completion.
  - The counter saturates and is never wrapped.
- ack_i/err_i sampled in IDLE are ignored, as are late acks after an abort.
- Only one outstanding transaction.
- Latency:
  - Command accepted in cycle N; stb_o in N+1.
  - Zero-wait slave: ack at N+2, rsp_valid_o at N+3.
  - Next command accepted earliest at N+3, with stb_o at N+4.
- rsp_dat_o, rsp_err_o and rsp_timeout_o return to 0 when rsp_valid_o falls.

Test Plan:
- Write adr=0x0004, dat=0xDEADBEEF, sel=0xF, slave zero-wait → stb_o one cycle, rsp_valid_o at N+3, rsp_err_o=0; readback of 0x0004 returns rsp_dat_o=0xDEADBEEF.
- Read with stall_i held high 3 cycles → adr_o/sel_o/we_o stable and stb_o high for 4 cycles; stb_o drops the cycle after stall_i=0; rsp_valid_o after ack.
- Slave asserts err_i (e.g. out-of-range adr=0xFFFF) → rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0, rsp_timeout_o=0; cyc_o low next cycle.
- TIMEOUT=8, slave never acks → rsp_valid_o with rsp_err_o=1 and rsp_timeout_o=1 after 8 REQ/WAIT cycles; a late ack_i is ignored and cmd_ready_o=1.
- rst_i pulsed low while in WAIT → cyc_o/stb_o low immediately, no rsp_valid_o; next command executes normally.
- Back-to-back commands with cmd_valid_i held high → second command accepted in the rsp_valid_o cycle of the first; ack_i and err_i both high on the second → rsp_err_o=1.

Source files
------------

// File: rtl/wb_master.sv
// Wishbone B4 pipelined single-transaction master: one command in, one bus cycle out,
// one response pulse back carrying read data and error/timeout status.
module wb_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 8,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  // response side
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  // wishbone bus
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  stall_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic        TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;

  logic [CNT_W-1:0]      cnt_inc;
  logic                  to_hit;
  logic                  complete;
  logic                  abort;

  // Saturating cycle counter value for this REQ/WAIT cycle and the timeout decision
  always_comb begin
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    to_hit  = TO_EN && (cnt_inc == CNT_W'(TIMEOUT));
  end

  // Next-state and registered-output logic; ack/err beats a coincident timeout
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = '0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cmd_valid_i) begin
          state_d = ST_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : '0;
          sel_d   = cmd_sel_i;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        if (!stall_i && (ack_i || err_i)) begin
          complete = 1'b1;
        end else if (to_hit) begin
          abort = 1'b1;
        end else if (!stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (ack_i || err_i) begin
          complete = 1'b1;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    if (complete || abort) begin
      state_d     = ST_IDLE;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
    end
    if (complete) begin
      rsp_err_d = err_i;
      rsp_dat_d = (err_i || we_q) ? '0 : dat_i;
    end
    if (abort) begin
      rsp_err_d = 1'b1;
      rsp_to_d  = 1'b1;
    end
  end

  // State and output registers; reset drops the bus at once without a response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign cyc_o         = cyc_q;
  assign stb_o         = stb_q;
  assign we_o          = we_q;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign sel_o         = sel_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: small pipelined slave model plus a response scoreboard.
module tb_wb_master;

  logic        clk_i;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [15:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;
  logic        err_i;
  logic        stall_i;

  // slave model controls
  logic        ack_s, err_s;
  logic        ack_force;
  logic        slv_mute;
  logic        slv_both;
  logic [31:0] mem [16];

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_master #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .GRANULE   (8),
    .TIMEOUT   (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .cmd_sel_i    (cmd_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .sel_o        (sel_o),
    .we_o         (we_o),
    .stb_o        (stb_o),
    .cyc_o        (cyc_o),
    .ack_i        (ack_i),
    .err_i        (err_i),
    .stall_i      (stall_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign ack_i = ack_s | ack_force;
  assign err_i = err_s;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Pipelined slave: registered ack/err one cycle after an accepted strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_s <= 1'b0;
      err_s <= 1'b0;
      dat_i <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      ack_s <= 1'b0;
      err_s <= 1'b0;
      if (cyc_o && stb_o && !stall_i && !slv_mute) begin
        if (adr_o == 16'hFFFF) begin
          err_s <= 1'b1;
          dat_i <= 32'hBAD0BAD0;
        end else begin
          ack_s <= 1'b1;
          err_s <= slv_both;
          if (we_o) begin
            mem[adr_o[5:2]] <= merge(mem[adr_o[5:2]], dat_o, sel_o);
            dat_i <= 32'hCAFEF00D;
          end else begin
            dat_i <= mem[adr_o[5:2]];
          end
        end
      end
    end
  end

  // Response monitor: pop the scoreboard on every pulse, idle fields must be zero
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_dat", 64'(rsp_dat_o), 64'(mon_e.dat));
          chk("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
          chk("rsp_timeout", 64'(rsp_timeout_o), 64'(mon_e.to));
        end
      end else begin
        chk("rsp_idle", 64'({rsp_dat_o, rsp_err_o, rsp_timeout_o}), 64'(0));
      end
    end
  end

  // Drive one command from a negedge; returns just after the accepting edge
  task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic exp_rsp,
                       input logic [31:0] edat, input logic eerr, input logic eto);
    rsp_t r;
    chk("issue_ready", 64'(cmd_ready_o), 64'(1));
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    if (exp_rsp) begin
      r.dat = edat;
      r.err = eerr;
      r.to  = eto;
      sb.push_back(r);
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    rsp_t r;
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    stall_i     = 1'b0;
    ack_force   = 1'b0;
    slv_mute    = 1'b0;
    slv_both    = 1'b0;

    // reset state
    @(negedge clk_i);
    chk("rst_cyc", 64'(cyc_o), 64'(0));
    chk("rst_stb", 64'(stb_o), 64'(0));
    chk("rst_ready", 64'(cmd_ready_o), 64'(1));
    chk("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_dat_o}), 64'(0));
    chk("rst_bus", 64'({adr_o, dat_o, sel_o, we_o}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // zero-wait write: stb one cycle, response at N+3
    issue(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("wr_stb", 64'(stb_o), 64'(1));
    chk("wr_cyc", 64'(cyc_o), 64'(1));
    chk("wr_we", 64'(we_o), 64'(1));
    chk("wr_adr", 64'(adr_o), 64'(16'h0004));
    chk("wr_dat", 64'(dat_o), 64'(32'hDEADBEEF));
    chk("wr_sel", 64'(sel_o), 64'(4'hF));
    chk("wr_busy", 64'(cmd_ready_o), 64'(0));
    @(negedge clk_i);
    chk("wr_stb_n2", 64'(stb_o), 64'(0));
    chk("wr_cyc_n2", 64'(cyc_o), 64'(1));
    chk("wr_rsp_n2", 64'(rsp_valid_o), 64'(0));
    @(negedge clk_i);
    chk("wr_rsp_n3", 64'(rsp_valid_o), 64'(1));
    chk("wr_cyc_n3", 64'(cyc_o), 64'(0));
    chk("wr_ready_n3", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    chk("wr_rsp_n4", 64'(rsp_valid_o), 64'(0));

    // readback; read drives dat_o to zero
    issue(1'b0, 16'h0004, 32'h12345678, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("rd_dat_o", 64'(dat_o), 64'(0));
    chk("rd_we", 64'(we_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rd_rsp_n3", 64'(rsp_valid_o), 64'(1));
    @(negedge clk_i);

    // read with three stalled edges: stb high four cycles
    stall_i = 1'b1;
    issue(1'b0, 16'h0004, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("stall_stb", 64'(stb_o), 64'(1));
      chk("stall_adr", 64'(adr_o), 64'(16'h0004));
      chk("stall_sel", 64'(sel_o), 64'(4'hF));
      chk("stall_we", 64'(we_o), 64'(0));
      if (i == 3) stall_i = 1'b0;
    end
    @(negedge clk_i);
    chk("stall_stb_drop", 64'(stb_o), 64'(0));
    chk("stall_cyc", 64'(cyc_o), 64'(1));
    chk("stall_rsp_early", 64'(rsp_valid_o), 64'(0));
    @(negedge clk_i);
    chk("stall_rsp", 64'(rsp_valid_o), 64'(1));
    @(negedge clk_i);

    // slave error
    issue(1'b0, 16'hFFFF, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("err_rsp", 64'(rsp_valid_o), 64'(1));
    chk("err_cyc", 64'(cyc_o), 64'(0));
    @(negedge clk_i);

    // timeout after 8 REQ/WAIT cycles, then a late ack is ignored
    slv_mute = 1'b1;
    issue(1'b0, 16'h0008, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      chk("to_cyc_hold", 64'(cyc_o), 64'(1));
    end
    @(negedge clk_i);
    chk("to_rsp", 64'(rsp_valid_o), 64'(1));
    chk("to_cyc", 64'(cyc_o), 64'(0));
    chk("to_stb", 64'(stb_o), 64'(0));
    ack_force = 1'b1;
    @(negedge clk_i);
    chk("late_ack_cyc", 64'(cyc_o), 64'(0));
    chk("late_ack_ready", 64'(cmd_ready_o), 64'(1));
    ack_force = 1'b0;
    @(negedge clk_i);
    chk("late_ack_idle", 64'({cyc_o, stb_o, rsp_valid_o}), 64'(0));
    slv_mute = 1'b0;

    // reset while in WAIT: bus drops at once, no response
    slv_mute = 1'b1;
    issue(1'b1, 16'h0010, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rstw_cyc_before", 64'(cyc_o), 64'(1));
    rst_i = 1'b0;
    #1;
    chk("rstw_cyc", 64'(cyc_o), 64'(0));
    chk("rstw_stb", 64'(stb_o), 64'(0));
    chk("rstw_rsp", 64'(rsp_valid_o), 64'(0));
    chk("rstw_ready", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    rst_i    = 1'b1;
    slv_mute = 1'b0;
    @(negedge clk_i);
    issue(1'b0, 16'h0004, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rstw_next_rsp", 64'(rsp_valid_o), 64'(1));
    @(negedge clk_i);

    // back-to-back with cmd_valid held; second sees ack and err together
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 16'h0020;
    cmd_dat_i   = 32'h11223344;
    cmd_sel_i   = 4'b0011;
    r.dat = 32'h0; r.err = 1'b0; r.to = 1'b0;
    sb.push_back(r);
    @(posedge clk_i);
    #1;
    cmd_we_i  = 1'b0;
    cmd_dat_i = 32'h55555555;
    cmd_sel_i = 4'hF;
    r.dat = 32'h0; r.err = 1'b1; r.to = 1'b0;
    sb.push_back(r);
    @(negedge clk_i);
    chk("b2b_sel", 64'(sel_o), 64'(4'b0011));
    chk("b2b_busy", 64'(cmd_ready_o), 64'(0));
    @(negedge clk_i);
    slv_both = 1'b1;
    @(negedge clk_i);
    chk("b2b_rsp1", 64'(rsp_valid_o), 64'(1));
    chk("b2b_ready", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    chk("b2b_stb2", 64'(stb_o), 64'(1));
    chk("b2b_we2", 64'(we_o), 64'(0));
    chk("b2b_dat2", 64'(dat_o), 64'(0));
    chk("b2b_sel2", 64'(sel_o), 64'(4'hF));
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("b2b_rsp2", 64'(rsp_valid_o), 64'(1));
    slv_both = 1'b0;
    @(negedge clk_i);

    // zero select passes through and writes nothing; partial write merged earlier
    issue(1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("sel0_sel", 64'(sel_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    issue(1'b0, 16'h0020, 32'h0, 4'hF, 1'b1, 32'h00003344, 1'b0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("sel_rd_rsp", 64'(rsp_valid_o), 64'(1));

    repeat (4) @(negedge clk_i);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the run stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
